// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: one-access-per-cycle arbiter for the single-port RC4 S-memory, with lock-based atomic sequences.
// Define S_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module s_mem_arbiter #(
  parameter int N      = 3,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    wr,
  input  logic [N-1:0]    lock,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rvalid,
  output logic [DW-1:0]   rdata,
  output logic            idle,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_wren,
  output logic            mem_rden,
  input  logic [DW-1:0]   mem_q
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TD = 1 + RD_LAT;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_a[gi]  = addr[gi*AW +: AW];
      assign wdata_a[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  logic                  owned_q, owned_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  win_any;
  logic [IW-1:0]         win_idx;
  logic                  rd_issue;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  mem_wren_q, mem_wren_d;
  logic                  mem_rden_q, mem_rden_d;
  logic [TD-1:0]         tag_vld_q, tag_vld_d;
  logic [TD-1:0][IW-1:0] tag_id_q, tag_id_d;

`ifdef S_MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction
`endif

  // Scanning from the lowest-priority candidate upward lets the highest-priority one overwrite last.
  always_comb begin : arbitrate
    win_any = 1'b0;
    win_idx = '0;
    if (reset) begin
      if (owned_q) begin
        win_any = req[owner_q];
        win_idx = owner_q;
      end else begin
`ifdef S_MEM_ARB_ROUND_ROBIN_EN
        for (int i = N - 1; i >= 0; i--) begin
          if (req[rr_slot(ptr_q, i)]) begin
            win_any = 1'b1;
            win_idx = rr_slot(ptr_q, i);
          end
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
          if (req[IW'(i)]) begin
            win_any = 1'b1;
            win_idx = IW'(i);
          end
        end
`endif
      end
    end
  end

  assign rd_issue = win_any & ~wr[win_idx];

  always_comb begin : next_state
    owned_d     = owned_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;

    // Ownership drops on the owner's lock alone, even when it is not requesting.
    if (owned_q) begin
      if (!lock[owner_q]) owned_d = 1'b0;
    end else if (win_any && lock[win_idx]) begin
      owned_d = 1'b1;
      owner_d = win_idx;
    end

    if (win_any) begin
      mem_addr_d  = addr_a[win_idx];
      mem_wdata_d = wdata_a[win_idx];
      mem_wren_d  = wr[win_idx];
      mem_rden_d  = ~wr[win_idx];
    end

    tag_vld_d = {tag_vld_q[TD-2:0], rd_issue};
    tag_id_d  = {tag_id_q[TD-2:0], win_idx};
  end

`ifdef S_MEM_ARB_ROUND_ROBIN_EN
  always_comb begin : next_ptr
    ptr_d = ptr_q;
    if (win_any && !owned_q) ptr_d = rr_slot(win_idx, 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owned_q     <= 1'b0;
      owner_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      owned_q     <= owned_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  // The last tag stage lines up with mem_q for the read issued RD_LAT+1 cycles earlier.
  assign gnt       = win_any ? (N'(1) << win_idx) : '0;
  assign rvalid    = tag_vld_q[TD-1] ? (N'(1) << tag_id_q[TD-1]) : '0;
  assign rdata     = mem_q;
  assign idle      = ~owned_q & ~(|tag_vld_q);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_rden  = mem_rden_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: directed phases plus a per-cycle model (owner, shadow RAM, return queue) compared every cycle.
module tb_s_mem_arbiter;
  localparam int N = 3, AW = 8, DW = 8, RD_LAT = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0, wr = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_q;
  logic [AW-1:0]   mem_addr;
  logic            idle, mem_wren, mem_rden;

  int pass_cnt = 0, total_cnt = 0, cyc = 0, txn = 0;

  always #5 clk = ~clk;

  s_mem_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .idle(idle), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  // Synchronous single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q = '0;
  initial for (int i = 0; i < 256; i++) ram[i] <= '0;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    if (mem_rden) ram_q <= ram[mem_addr];
  end
  assign mem_q = ram_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model state
  typedef struct { int due; int k; logic [7:0] d; } ret_t;
  ret_t        rq[$];
  logic [7:0]  shadow [256];
  int          m_owner = -1, m_ptr = 0;
  logic        e_wren = 0, e_rden = 0;
  logic [7:0]  e_addr = 0, e_wdata = 0;

  function automatic int model_pick();
    if (m_owner >= 0) return req[2'(m_owner)] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
`ifdef S_MEM_ARB_ROUND_ROBIN_EN
      int c = (m_ptr + i) % N;
`else
      int c = i;
`endif
      if (req[2'(c)]) return c;
    end
    return -1;
  endfunction

  initial begin : compare
    int         w;
    logic [N-1:0] eg, erv;
    logic [7:0] ed;
    logic       eidle;
    ret_t       r;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        chk("rst_mem_rden", 32'(mem_rden), 0);
        chk("rst_idle", 32'(idle), 1);
        m_owner = -1; m_ptr = 0;
        e_wren = 0; e_rden = 0; e_addr = 0; e_wdata = 0;
        rq.delete();
      end else begin
        w     = model_pick();
        eg    = (w >= 0) ? (N'(1) << w) : '0;
        eidle = (m_owner < 0) && (rq.size() == 0);
        erv   = '0;
        ed    = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          erv = N'(1) << rq[0].k;
          ed  = rq[0].d;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (erv != 0) chk("rdata", 32'(rdata), 32'(ed));
        chk("mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("mem_rden", 32'(mem_rden), 32'(e_rden));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("idle", 32'(idle), 32'(eidle));
        if (erv != 0) void'(rq.pop_front());
        if (w >= 0) begin
          e_addr  = addr[w*AW +: AW];
          e_wdata = wdata[w*DW +: DW];
          e_wren  = wr[2'(w)];
          e_rden  = !wr[2'(w)];
          if (wr[2'(w)]) shadow[e_addr] = e_wdata;
          else begin
            r.due = cyc + 1 + RD_LAT; r.k = w; r.d = shadow[e_addr];
            rq.push_back(r);
          end
        end else begin
          e_wren = 0; e_rden = 0;
        end
        if (m_owner >= 0) begin
          if (!lock[2'(m_owner)]) m_owner = -1;
        end else if (w >= 0) begin
          if (lock[2'(w)]) m_owner = w;
          m_ptr = (w + 1) % N;
        end
      end
    end
  end

  // Longest run of consecutive write-enable cycles.
  int wren_run = 0, wren_max = 0;
  always @(negedge clk) begin
    if (mem_wren) wren_run = wren_run + 1;
    else          wren_run = 0;
    if (wren_run > wren_max) wren_max = wren_run;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int k, input logic w, input logic [7:0] a, input logic [7:0] d, input logic lk);
    bit got;
    logic [1:0] kk;
    got = 0;
    kk  = 2'(k);
    req[kk] = 1'b1; wr[kk] = w; lock[kk] = lk;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (gnt[kk]) got = 1;
    end
    chk("grant_wait", 32'(got), 1);
    txn++;
    if (w) $display("txn %0d: req%0d write addr=%02h data=%02h lock=%0d", txn, k, a, d, lk);
    else   $display("txn %0d: req%0d read  addr=%02h lock=%0d", txn, k, a, lk);
    tick();
    req[kk] = 1'b0;
  endtask

  task automatic read_back(input logic [7:0] a, output logic [7:0] d);
    bit seen;
    seen = 0;
    d = '0;
    do_access(0, 1'b0, a, 8'h00, 1'b0);
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (rvalid[0]) begin seen = 1; d = rdata; end
    end
    chk("readback_wait", 32'(seen), 1);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         ord [3];
    int         nord, c0;
    logic [N-1:0] g;
    logic [7:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_idle", 32'(idle), 1);
    chk("lit_rst_gnt", 32'(gnt), 0);
    tick();
    reset = 1'b1;

    // Single write then read of address 05
    req[0] = 1'b1; wr[0] = 1'b1; addr[7:0] = 8'h05; wdata[7:0] = 8'hA5;
    @(negedge clk); chk("t1_gnt_c0", 32'(gnt), 1);
    tick(); wr[0] = 1'b0;
    @(negedge clk); chk("t1_gnt_c1", 32'(gnt), 1); chk("t1_wren_c1", 32'(mem_wren), 1);
    tick(); req[0] = 1'b0;
    @(negedge clk); chk("t1_rden_c2", 32'(mem_rden), 1); chk("t1_wren_c2", 32'(mem_wren), 0);
    tick();
    @(negedge clk); chk("t1_rvalid_c3", 32'(rvalid), 1); chk("t1_rdata_c3", 32'(rdata), 32'hA5);
    tick();

    // Seed values for contention and swap phases
    do_access(0, 1'b1, 8'd10, 8'h11, 1'b0);
    do_access(0, 1'b1, 8'd20, 8'h22, 1'b0);
    do_access(0, 1'b1, 8'd30, 8'h33, 1'b0);
    do_access(0, 1'b1, 8'd3,  8'hC3, 1'b0);
    do_access(0, 1'b1, 8'd7,  8'hE7, 1'b0);

    // Three simultaneous reads
    for (int i = 0; i < 3; i++) ord[i] = -1;
    nord = 0;
    req = 3'b111; wr = 3'b000; lock = 3'b000; addr = {8'd30, 8'd20, 8'd10};
    for (int n = 0; n < 10 && req != 0; n++) begin
      @(negedge clk);
      g = gnt;
      for (int k = 0; k < N; k++) if (g[2'(k)] && nord < 3) begin ord[nord] = k; nord++; end
      tick();
      req = req & ~g;
    end
`ifdef S_MEM_ARB_ROUND_ROBIN_EN
    chk("t2_order0", 32'(ord[0]), 1); chk("t2_order1", 32'(ord[1]), 2); chk("t2_order2", 32'(ord[2]), 0);
`else
    chk("t2_order0", 32'(ord[0]), 0); chk("t2_order1", 32'(ord[1]), 1); chk("t2_order2", 32'(ord[2]), 2);
`endif
    repeat (4) tick();

    // Locked swap of S[3] and S[7] with requester 2 contending
    req[2] = 1'b1; wr[2] = 1'b0; addr[23:16] = 8'd30;
    do_access(1, 1'b0, 8'd3, 8'h00, 1'b1);
    do_access(1, 1'b0, 8'd7, 8'h00, 1'b1);
    do_access(1, 1'b1, 8'd3, 8'hE7, 1'b1);
    do_access(1, 1'b1, 8'd7, 8'hC3, 1'b0);
    @(negedge clk); chk("t3_gnt2_after_unlock", 32'(gnt), 4);
    tick(); req[2] = 1'b0;
    repeat (3) tick();
    chk("t3_s3", 32'(ram[3]), 32'hE7);
    chk("t3_s7", 32'(ram[7]), 32'hC3);

    // Owner holds lock with no request
    do_access(1, 1'b0, 8'd5, 8'h00, 1'b1);
    req[0] = 1'b1; wr[0] = 1'b0; addr[7:0] = 8'd5;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t4_gnt_locked", 32'(gnt), 0);
      if (n > 0) begin
        chk("t4_wren_locked", 32'(mem_wren), 0);
        chk("t4_rden_locked", 32'(mem_rden), 0);
      end
      tick();
    end
    lock[1] = 1'b0;
    @(negedge clk); chk("t4_gnt_unlock_cycle", 32'(gnt), 0);
    tick();
    @(negedge clk); chk("t4_gnt0_after", 32'(gnt), 1);
    tick(); req[0] = 1'b0;
    repeat (3) tick();

    // Init sweep S[i] = i
    wren_max = 0;
    c0 = cyc;
    for (int i = 0; i < 256; i++) do_access(0, 1'b1, 8'(i), 8'(i), 1'b0);
    chk("t5_sweep_cycles", 32'(cyc - c0), 256);
    repeat (2) tick();
    chk("t5_wren_run", 32'(wren_max), 256);
    read_back(8'd0,   rb); chk("t5_rb_0",   32'(rb), 0);
    read_back(8'd128, rb); chk("t5_rb_128", 32'(rb), 128);
    read_back(8'd255, rb); chk("t5_rb_255", 32'(rb), 255);

    // Reset while a read is in flight
    do_access(2, 1'b0, 8'd10, 8'h00, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rden_in_reset", 32'(mem_rden), 0);
    chk("t6_idle_in_reset", 32'(idle), 1);
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t6_no_rvalid", 32'(rvalid), 0);
      chk("t6_idle", 32'(idle), 1);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Arbitrates the single-port 256x8 RC4 S-memory among the three phase engines: init (requester 0), key schedule/swap (requester 1) and PRGA decode (requester 2).
- Grants at most one access per cycle and drives the RAM port from registers.
- Routes read data back to the requester that issued the read, with a per-requester valid strobe.
- Supports a lock so a requester can make multi-access sequences atomic, e.g. the KSA read-i/read-j/write-i/write-j swap.

Parameters:
- N, 3, number of requesters
- AW, 8, address width
- DW, 8, data width
- RD_LAT, 1, RAM read latency in cycles from the RAM latching its address to mem_q being valid (1..4)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req  input  N  per-requester access request
- wr  input  N  per-requester 1=write, 0=read; qualified by req
- lock  input  N  per-requester hold ownership after the current grant
- addr  input  N*AW  packed addresses; requester k uses bits [k*AW +: AW]
- wdata  input  N*DW  packed write data, same packing as addr
- gnt  output  N  one-hot grant; combinational in the request cycle
- rvalid  output  N  one-hot read-return strobe
- rdata  output  DW  read data, shared by all requesters; equals mem_q
- idle  output  1  high when no read is in flight and no owner is held
- mem_addr  output  AW  RAM address, registered
- mem_wdata  output  DW  RAM write data, registered
- mem_wren  output  1  RAM write enable, registered
- mem_rden  output  1  RAM read enable, registered
- mem_q  input  DW  RAM read data

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - gnt=0, rvalid=0
  - mem_addr=0, mem_wdata=0, mem_wren=0, mem_rden=0
  - owner cleared, round-robin pointer cleared to 0, read tag pipeline cleared
  - idle=1
- Reset asserted mid-operation drops all in-flight reads; no rvalid is produced for them after release.
- Owner register has states NONE and OWNED(k).
  - NONE: winner is chosen from the requesters with req high, by the arbitration rule.
  - OWNED(k): only requester k can be granted. All other requests stall with gnt low, regardless of priority.
  - Enter OWNED(k) at the edge ending a cycle in which gnt[k]=1 and lock[k]=1.
  - Return to NONE at the first edge where the owner has lock[k]=0. This holds whether or not k is requesting; a granted access with lock low in the same cycle completes, then ownership releases.
  - An owner that drops req but keeps lock high holds the port idle.
- Arbitration rule without the optional feature: fixed priority, lowest index wins.
- Grant timing:
  - gnt[k] is high in the same cycle as req[k] when k wins; this is the grant cycle T.
  - The requester must hold addr, wdata and wr stable through T. The access is accepted at the edge ending T.
  - A requester that is not granted keeps req high; a request is never dropped silently.
- Issue: at the edge ending T the block registers mem_addr, mem_wdata, mem_wren=wr[k] and mem_rden=~wr[k]. The RAM sees the access in cycle T+1.
- With no grant in a cycle, mem_wren=mem_rden=0 the next cycle. mem_addr and mem_wdata hold their previous values.
- Read return:
  - A read granted in T produces rvalid[k]=1 for exactly one cycle, in cycle T+1+RD_LAT.
  - rdata=mem_q in that cycle.
  - The requester id is tracked in a tag shift register of depth 1+RD_LAT, so back-to-back reads by different requesters each return in order, one per cycle.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive grants returns the new data; the RAM is the ordering point.
- idle is high when the tag pipeline is empty and the owner is NONE.

Optional Feature:
- Macro: S_MEM_ARB_ROUND_ROBIN_EN.
- Defined: arbitration in state NONE is round-robin.
  - Search starts at the pointer, which is reset to 0.
  - After a grant to k, the pointer becomes (k+1) mod N.
  - Ownership rules are unchanged, and the pointer is not updated while OWNED.
- Undefined: fixed priority, and no pointer register exists.

Test Plan:
- Single write then read: req0 writes addr 8'h05 with data 8'hA5 at cycle 0, then req0 reads 8'h05 at cycle 1.
  - Expect gnt[0] in cycles 0 and 1, mem_wren in cycle 1, mem_rden in cycle 2.
  - Expect rvalid[0]=1 with rdata=8'hA5 in cycle 3 (RD_LAT=1).
- Contention: req0, req1 and req2 all reading in the same cycle.
  - Fixed priority: grant order 0,1,2, one per cycle; rvalid returns 0,1,2 on consecutive cycles.
  - Round-robin with the pointer at 1: order 1,2,0.
- Lock: req1 locks and performs a 4-access swap (read 3, read 7, write 3, write 7) while req2 requests continuously.
  - gnt[2] stays 0 until the cycle after lock[1] falls.
  - S[3] and S[7] end up exchanged.
- Locked idle: req1 holds lock=1 with req=0 for 3 cycles while req0 requests.
  - No grants for those 3 cycles and mem_wren=mem_rden=0.
  - gnt[0] asserts the cycle after the lock drops.
- Init sweep: req0 writes addr i with data i for i=0..255 back-to-back.
  - Expect 256 consecutive grants and mem_wren high for 256 cycles.
  - Read-back of addresses 0, 128 and 255 returns 0, 128 and 255.
- Reset mid-read: assert reset in cycle T+1 after a read granted in T.
  - No rvalid afterwards; all outputs at their reset values; idle=1.
